i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one I2C master controller (start/add_reg/R_W/data_1/data_2 in, free out) among NUM_REQ requesters.
- Latches the winning requester's transaction and pulses the master's start.
- Tracks the master's free flag through the transaction and returns a per-requester done pulse.
- Enforces an idle gap between back-to-back bus transactions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_LEN, 7, slave address width.
- DATA_LEN, 8, data byte width.
- GAP_CYCLES, 8, minimum clk cycles in IDLE after a transaction before the next grant (1..255).
- TIMEOUT_CYCLES, 4096, watchdog limit per transaction (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  request level per requester; held until its done.
- req_addr  in  NUM_REQ*ADDR_LEN  packed addresses; requester i at [i*ADDR_LEN +: ADDR_LEN].
- req_rw  in  NUM_REQ  R_W per requester.
- req_data_1  in  NUM_REQ*DATA_LEN  packed first data bytes.
- req_data_2  in  NUM_REQ*DATA_LEN  packed second data bytes.
- gnt  out  NUM_REQ  one-hot grant, high from grant until done.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with done on watchdog abort (always 0 without the feature).
- busy  out  1  high in any state except IDLE.
- m_start  out  1  start to the master.
- m_add_reg  out  ADDR_LEN  latched address.
- m_R_W  out  1  latched R_W.
- m_data_1  out  DATA_LEN  latched data_1.
- m_data_2  out  DATA_LEN  latched data_2.
- m_free  in  1  master idle flag.

Behaviour:
- Reset (async, rst=1): state IDLE; gnt, done, err, busy, m_start = 0; m_add_reg, m_R_W, m_data_* = 0; rr_ptr = 0; gap counter = GAP_CYCLES (gap already satisfied).
- Mid-operation reset aborts the transaction with no done pulse. The master is not reset by this block.
- All outputs are registered.
- IDLE:
  - Gap counter increments, saturating at GAP_CYCLES.
  - When gap counter == GAP_CYCLES, m_free == 1 and |req: select the first set req bit searching upward from rr_ptr with wrap at NUM_REQ.
  - Next cycle: gnt[g]=1, payload slices of g latched into m_* regs, m_start=1, state LAUNCH.
- LAUNCH:
  - m_start held high until m_free sampled 0; then m_start=0 and state WAIT_FREE.
- WAIT_FREE:
  - Wait for m_free == 1, then state DONE.
- DONE (one cycle):
  - done[g]=1; gnt cleared.
  - rr_ptr = (g+1) mod NUM_REQ; gap counter = 0; state IDLE.
- Latency: req to m_start = 1 cycle when eligible. m_free rising to done = 1 cycle.
- Payload is latched at grant. Requester input changes afterwards have no effect.
- req[g] dropping while granted is ignored: the transaction completes and done still pulses.
- A requester still asserting req after its done is eligible again, but only after the others by round-robin order.
- Only one gnt bit is ever high. done is never high for a non-granted requester.
- Arrivals of other reqs during a transaction are held off until the next IDLE arbitration.
- m_free == 0 in IDLE (bus still busy) blocks grants; the gap counter keeps counting.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- With the macro:
  - Watchdog counter clears at grant and increments in LAUNCH and WAIT_FREE.
  - On reaching TIMEOUT_CYCLES-1: m_start=0, state DONE, err=1 with done[g].
  - rr_ptr advances as normal.
- Without the macro:
  - No counter logic.
  - err tied 0.
  - LAUNCH and WAIT_FREE wait indefinitely.

Test Plan:
- Single request: req=4'b0010, addr 7'h50, rw 0, data 8'hA5/8'h3C. Required:
  - gnt=0010 one cycle later.
  - m_add_reg=7'h50, m_data_1=8'hA5, m_data_2=8'h3C.
  - m_start drops the cycle after m_free falls.
  - done=0010 one cycle after m_free rises.
- Round robin: req=4'b1111 held. Required:
  - Grant order 0,1,2,3,0.
  - At least GAP_CYCLES=8 idle cycles between each done and the next m_start.
- Payload hold: change req_addr[1] from 7'h20 to 7'h21 after grant. Required: m_add_reg stays 7'h20 until done.
- Busy bus: m_free=0 in IDLE with req=0001. Required:
  - No gnt while m_free=0.
  - Grant one cycle after m_free returns to 1.
- Reset mid-transaction: assert rst in WAIT_FREE. Required:
  - All outputs 0 immediately (asynchronous).
  - No done pulse.
  - After release, req=0100 wins (rr_ptr=0 and only req[2] is set).
- With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64: hold m_free=1 so the master never responds. Required:
  - done and err pulse together exactly 64 cycles after grant.
  - Next requester then granted.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters, with an inter-transaction idle gap.
// Optional per-transaction watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_LEN       = 7,
  parameter int DATA_LEN       = 8,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]           req_rw,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data_1,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data_2,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         err,
  output logic                         busy,
  output logic                         m_start,
  output logic [ADDR_LEN-1:0]          m_add_reg,
  output logic                         m_R_W,
  output logic [DATA_LEN-1:0]          m_data_1,
  output logic [DATA_LEN-1:0]          m_data_2,
  input  logic                         m_free
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1 = IW + 1;

  // Elaboration marker only: this block exists solely when a parameter is out of range.
  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 2)
  begin : g_param_out_of_range
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_FREE, DONE} state_t;

  // Handshake: m_start is raised at grant and held until the master is seen busy (m_free=0);
  // the transaction ends when m_free returns to 1. done/err are single-cycle pulses to the owner.
  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   sel;
  logic [IW1-1:0]  idx;
  logic            found;
  logic [7:0]      gap_cnt;
  logic            gap_ok;
  logic            wd_expire;

  assign gap_ok = (gap_cnt == 8'(GAP_CYCLES));

  // First set request searching upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + IW1'(k);
      if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_add_reg <= '0;
      m_R_W     <= 1'b0;
      m_data_1  <= '0;
      m_data_2  <= '0;
      rr_ptr    <= '0;
      cur       <= '0;
      gap_cnt   <= 8'(GAP_CYCLES);
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (!gap_ok) gap_cnt <= gap_cnt + 8'd1;
          if (gap_ok && m_free && found) begin
            state     <= LAUNCH;
            gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            cur       <= sel;
            m_add_reg <= req_addr[sel*ADDR_LEN +: ADDR_LEN];
            m_R_W     <= req_rw[sel];
            m_data_1  <= req_data_1[sel*DATA_LEN +: DATA_LEN];
            m_data_2  <= req_data_2[sel*DATA_LEN +: DATA_LEN];
            m_start   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LAUNCH: begin
          if (wd_expire) begin
            m_start <= 1'b0;
            state   <= DONE;
            done    <= gnt;
            gnt     <= '0;
          end else if (!m_free) begin
            m_start <= 1'b0;
            state   <= WAIT_FREE;
          end
        end
        WAIT_FREE: begin
          if (wd_expire || m_free) begin
            state <= DONE;
            done  <= gnt;
            gnt   <= '0;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          rr_ptr  <= (cur == IW'(NUM_REQ-1)) ? '0 : cur + IW'(1);
          gap_cnt <= 8'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  logic [WW-1:0] wdog;
  logic          in_txn;

  assign in_txn    = (state == LAUNCH) || (state == WAIT_FREE);
  assign wd_expire = in_txn && (wdog == WW'(TIMEOUT_CYCLES-1));

  // Counter is zero on the first LAUNCH cycle, so expiry lands TIMEOUT_CYCLES cycles after grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      err <= wd_expire;
      if (!in_txn) wdog <= '0;
      else         wdog <= wdog + WW'(1);
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: single txn, payload hold, busy bus, async reset, round robin,
// and (with I2C_ARB_TIMEOUT_EN) the watchdog abort.
module tb_i2c_txn_arbiter;
  localparam int NUM_REQ        = 4;
  localparam int ADDR_LEN       = 7;
  localparam int DATA_LEN       = 8;
  localparam int GAP_CYCLES     = 8;
  localparam int TIMEOUT_CYCLES = 64;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*ADDR_LEN-1:0] req_addr;
  logic [NUM_REQ-1:0]          req_rw;
  logic [NUM_REQ*DATA_LEN-1:0] req_data_1;
  logic [NUM_REQ*DATA_LEN-1:0] req_data_2;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          done;
  logic                        err;
  logic                        busy;
  logic                        m_start;
  logic [ADDR_LEN-1:0]         m_add_reg;
  logic                        m_R_W;
  logic [DATA_LEN-1:0]         m_data_1;
  logic [DATA_LEN-1:0]         m_data_2;
  logic                        m_free;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_start  = 0;
  int t_done   = 0;

  i2c_txn_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_data_1(req_data_1), .req_data_2(req_data_2), .gnt(gnt), .done(done),
    .err(err), .busy(busy), .m_start(m_start), .m_add_reg(m_add_reg), .m_R_W(m_R_W),
    .m_data_1(m_data_1), .m_data_2(m_data_2), .m_free(m_free)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_payload(input int i, input logic [ADDR_LEN-1:0] a, input logic rw,
                             input logic [DATA_LEN-1:0] d1, input logic [DATA_LEN-1:0] d2);
    req_addr[i*ADDR_LEN +: ADDR_LEN]   = a;
    req_rw[i]                          = rw;
    req_data_1[i*DATA_LEN +: DATA_LEN] = d1;
    req_data_2[i*DATA_LEN +: DATA_LEN] = d2;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (m_start === 1'b1) break;
      @(negedge clk);
    end
    chk({tag, "_start"}, 32'(m_start), 32'd1);
    t_start = cyc;
  endtask

  // Master model: go busy, stay busy one cycle, then go free; expect done one cycle later.
  task automatic finish_txn(input logic [NUM_REQ-1:0] exp_gnt, input string tag);
    m_free = 1'b0;
    @(negedge clk);
    chk({tag, "_start_drop"}, 32'(m_start), 32'd0);
    chk({tag, "_gnt_held"}, 32'(gnt), 32'(exp_gnt));
    @(negedge clk);
    chk({tag, "_no_early_done"}, 32'(done), 32'd0);
    m_free = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'(exp_gnt));
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
    t_done = cyc;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_rw = '0;
    req_data_1 = '0; req_data_2 = '0; m_free = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(m_start), 32'd0);
    chk("rst_addr", 32'(m_add_reg), 32'd0);
    rst = 1'b0;

    // Single request: gap already satisfied, grant 1 cycle after req
    set_payload(1, 7'h50, 1'b0, 8'hA5, 8'h3C);
    req = 4'b0010;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_start", 32'(m_start), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_addr", 32'(m_add_reg), 32'h50);
    chk("t1_rw", 32'(m_R_W), 32'd0);
    chk("t1_d1", 32'(m_data_1), 32'hA5);
    chk("t1_d2", 32'(m_data_2), 32'h3C);
    @(negedge clk);
    chk("t1_start_hold", 32'(m_start), 32'd1);
    finish_txn(4'b0010, "t1");
    req = 4'b0000;

    // Payload hold: inputs change and req drops after grant; txn still completes
    set_payload(1, 7'h20, 1'b1, 8'h11, 8'h22);
    req = 4'b0010;
    wait_start("pay");
    chk("pay_gnt", 32'(gnt), 32'h2);
    chk("pay_addr", 32'(m_add_reg), 32'h20);
    chk("pay_rw", 32'(m_R_W), 32'd1);
    set_payload(1, 7'h21, 1'b0, 8'h99, 8'h88);
    req = 4'b0000;
    @(negedge clk);
    chk("pay_addr_hold", 32'(m_add_reg), 32'h20);
    chk("pay_d1_hold", 32'(m_data_1), 32'h11);
    finish_txn(4'b0010, "pay");
    chk("pay_addr_after", 32'(m_add_reg), 32'h20);

    // Busy bus: m_free low in IDLE blocks grants even after the gap elapses
    m_free = 1'b0;
    set_payload(0, 7'h33, 1'b0, 8'h01, 8'h02);
    req = 4'b0001;
    repeat (15) @(negedge clk);
    chk("bus_no_gnt", 32'(gnt), 32'd0);
    chk("bus_no_start", 32'(m_start), 32'd0);
    m_free = 1'b1;
    @(negedge clk);
    chk("bus_gnt", 32'(gnt), 32'h1);
    chk("bus_addr", 32'(m_add_reg), 32'h33);
    finish_txn(4'b0001, "bus");
    req = 4'b0000;

    // Asynchronous reset during WAIT_FREE
    set_payload(1, 7'h44, 1'b1, 8'h55, 8'h66);
    req = 4'b0010;
    wait_start("mrst");
    chk("mrst_gnt", 32'(gnt), 32'h2);
    m_free = 1'b0;
    @(negedge clk);
    req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("mrst_gnt0", 32'(gnt), 32'd0);
    chk("mrst_start0", 32'(m_start), 32'd0);
    chk("mrst_busy0", 32'(busy), 32'd0);
    chk("mrst_done0", 32'(done), 32'd0);
    chk("mrst_addr0", 32'(m_add_reg), 32'd0);
    chk("mrst_rw0", 32'(m_R_W), 32'd0);
    chk("mrst_d1_0", 32'(m_data_1), 32'd0);
    @(negedge clk);
    m_free = 1'b1;
    rst    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_done", 32'(done), 32'd0);
    end
    set_payload(2, 7'h55, 1'b0, 8'h77, 8'h78);
    req = 4'b0100;
    @(negedge clk);
    chk("mrst_regnt", 32'(gnt), 32'h4);
    chk("mrst_readdr", 32'(m_add_reg), 32'h55);
    finish_txn(4'b0100, "mrst");
    req = 4'b0000;

    // Round robin from rr_ptr=0 with all requests held
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_payload(i, 7'(8'h10 + i), 1'b0, 8'(i), 8'(i + 4));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start("rr");
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      chk("rr_addr", 32'(m_add_reg), 32'(8'h10 + (k % 4)));
      // done cycle, one DONE-exit edge, 8 IDLE cycles of gap counting, then the grant edge
      if (k > 0) chk("rr_gap", 32'(t_start - t_done), 32'(GAP_CYCLES + 2));
      finish_txn(4'(1 << (k % 4)), "rr");
    end
    req = 4'b0000;

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: master never goes busy
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_free = 1'b1;
    req = 4'b0011;
    wait_start("wd");
    chk("wd_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done !== 4'b0000) break;
    end
    chk("wd_done", 32'(done), 32'h1);
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_start_drop", 32'(m_start), 32'd0);
    chk("wd_latency", 32'(cyc - t_start), 32'(TIMEOUT_CYCLES));
    @(negedge clk);
    chk("wd_err_pulse", 32'(err), 32'd0);
    wait_start("wd_next");
    chk("wd_next_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
